// File: rtl/sub_pkg.sv
// sub_pkg: shared state encodings and default width for the serial subtractor.
package sub_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    localparam int SUB_WIDTH_DEF = 8;
endpackage

// File: rtl/sub_bit_cell.sv
// sub_bit_cell: combinational 1-bit full subtractor built from two half-subtract stages.
module sub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d1;
    logic b1;
    logic b2;
    assign d1   = a ^ b;
    assign b1   = ~a & b;
    assign d    = d1 ^ bin;
    assign b2   = ~d1 & bin;
    assign bout = b1 | b2;
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: LSB-first bit-serial subtractor a-b through one 1-bit cell.
// Optional a_lt_b/a_eq_b compare flags are built when SUB_CMP_EN is defined.
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB_CMP_EN
    ,
    output logic             a_lt_b,
    output logic             a_eq_b
`endif
);
    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, r_sh_q, r_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, borrow_q, borrow_d;
    logic             cell_d, cell_bout;
    logic [WIDTH-1:0] res;

    sub_bit_cell u_cell (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .bin (br_q),
        .d   (cell_d),
        .bout(cell_bout)
    );

    assign res = {cell_d, r_sh_q[WIDTH-1:1]};

`ifdef SUB_CMP_EN
    logic lt_q, lt_d, eq_q, eq_d;
    assign a_lt_b = lt_q;
    assign a_eq_b = eq_q;
`endif

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SUB_CMP_EN
        lt_d     = lt_q;
        eq_d     = eq_q;
`endif
        case (state_q)
            ST_IDLE: if (start) begin
                a_sh_d  = a;
                b_sh_d  = b;
                br_d    = 1'b0;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                r_sh_d = res;
                br_d   = cell_bout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d   = res;
                    borrow_d = cell_bout;
`ifdef SUB_CMP_EN
                    lt_d     = cell_bout;
                    eq_d     = (res == '0);
`endif
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SUB_CMP_EN
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SUB_CMP_EN
            lt_q     <= lt_d;
            eq_q     <= eq_d;
`endif
        end
    end

    // Status decoded from registered state only, so no input-to-output path.
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
endmodule
